vend_display_scan: RTL and testbench
====================================

Name: vend_display_scan

Overview:
- Downstream consumer of the vending-machine controller; drives the board's 4-digit multiplexed 7-segment display from the controller's outputs.
- Inputs: the controller's money register (binary), its 1-bit state, and its three active-low drop_* availability flags.
- Shows the balance in decimal, the number of purchasable drinks, and a 'C' marker during change return, with the balance blinking while change returns.
- Contains the refresh prescaler, digit scanner, frame snapshot register and blink timer.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays enabled (>=2)
BLINK_DIV, 16, scan frames per blink half-period (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-high (1 = reset), sampled on rising clk
money  input  8  current balance, binary, nominal 0..50
state  input  1  controller state: 0 = idle/accept, 1 = change return
drop_tea  input  1  active-low: tea purchasable
drop_coke  input  1  active-low: coke purchasable
drop_sprite  input  1  active-low: sprite purchasable
DIGIT  output  4  active-low digit enables; bit0 = rightmost digit
DISPLAY  output  8  active-low segments: bit0..6 = a..g, bit7 = dp

Behaviour:
- Single clock domain. All state changes occur on rising clk. DIGIT and DISPLAY are registered, with no combinational path from inputs.
- Reset (rst_n=1): refresh counter=0, digit index=0, snapshot={money=0, state=0, avail=0}, frame counter=0, blink phase=0, DIGIT=4'b1110, DISPLAY=8'hC0 ("0"). Reset mid-scan takes effect on the next edge. Outputs hold reset values for as long as rst_n stays high.
- Refresh counter counts 0..REFRESH_DIV-1, then wraps. On the wrap edge, digit index advances 0->1->2->3->0. On the same edge, DIGIT/DISPLAY load the pattern for the new index. Each digit is lit for exactly REFRESH_DIV cycles. Exactly one DIGIT bit is low at all times after reset.
- Snapshot: on the edge where the index goes 3->0, register money, state and avail_cnt. avail_cnt = number of drop_* inputs at 0, range 0..3. A whole frame renders from one snapshot, so there is no tearing. Input changes are visible at the next frame start, with a latency of at most 4*REFRESH_DIV cycles.
- Value mapping: disp = min(snap_money, 99); tens = disp/10; ones = disp%10.
  - Digit0 = ones. Its dp is lit (bit7=0) iff snap_money > 99, as an overflow flag.
  - Digit1 = tens. Blank (8'hFF) when tens=0 (leading-zero blanking).
  - Digit2 = avail_cnt glyph.
  - Digit3 = 'C' (8'hC6) when snap_state=1, else blank.
- Glyphs: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 C=C6 blank=FF.
- Blink:
  - When snap_state=0: frame counter and blink phase are held at 0.
  - When snap_state=1: frame counter increments at each frame start. When it reaches BLINK_DIV-1 it clears and the blink phase toggles.
  - Blink phase=1 blanks digits 1:0, including dp. Digits 2 and 3 never blink.
  - Each entry into change return therefore starts with the balance visible.
- Simultaneous events: a frame-start snapshot and a blink toggle on the same edge are both applied. The new frame renders with the newly toggled phase.
- Width rules: the refresh counter is wide enough for REFRESH_DIV-1, and the frame counter for BLINK_DIV-1. No counter overflows. money 100..255 displays "99" with dp.

Test Plan (REFRESH_DIV=4, BLINK_DIV=2):
1. Reset, then money=35, state=0, all drop_*=0. After the first frame wrap, the scan shows digit0=92 ("5"), digit1=B0 ("3"), digit2=B0 ("3"), digit3=FF. Each DIGIT value holds exactly 4 cycles, in sequence 1110,1101,1011,0111.
2. money=5, drop_tea=0, others=1. Digit1=FF (leading zero blanked), digit0=92, digit2=F9. With money=0: digit0=C0, digit1=FF.
3. Change money mid-frame (while digit 2 is lit) from 20 to 45. The remainder of the frame still shows 20. The next frame shows 45.
4. state=1 with money=30. Digit3=C6. Digits 1:0 show "30" for 2 frames, then FF,FF for 2 frames, then repeat. Return state to 0: the balance shows steady from the next frame and the blink restarts visible on the next entry.
5. money=8'd120. Displays "99" with digit0 DISPLAY=8'h10 (dp lit).
6. Assert rst_n for 1 cycle mid-frame with state=1. On the next edge DIGIT=1110, DISPLAY=C0, and blink phase=0. Scan resumes from digit0 with a full 4-cycle dwell.

Source files
------------

// File: rtl/vend_display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vend_display_scan                                               |
// | Purpose  : 4-digit multiplexed 7-segment scanner for the vending display:  |
// |            balance, purchasable-drink count, change-return marker.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vend_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] money,
    input  logic       state,
    input  logic       drop_tea,
    input  logic       drop_coke,
    input  logic       drop_sprite,
    output logic [3:0] DIGIT,
    output logic [7:0] DISPLAY
);

    localparam int c_REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_REF_W-1:0] c_REF_MAX   = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_FRM_W-1:0] c_FRM_MAX   = c_FRM_W'(BLINK_DIV - 1);
    localparam logic [7:0]         c_SEG_BLANK = 8'hFF;
    localparam logic [7:0]         c_SEG_C     = 8'hC6;

    logic [c_REF_W-1:0] r_ref_cnt;
    logic [1:0]         r_digit_idx;
    logic [7:0]         r_snap_money;
    logic               r_snap_state;
    logic [1:0]         r_snap_avail;
    logic [c_FRM_W-1:0] r_frame_cnt;
    logic               r_blink;

    logic               w_wrap;
    logic               w_frame_start;
    logic [1:0]         w_next_idx;
    logic [1:0]         w_avail;
    logic [7:0]         w_nxt_money;
    logic               w_nxt_state;
    logic [1:0]         w_nxt_avail;
    logic [c_FRM_W-1:0] w_nxt_frame;
    logic               w_nxt_blink;
    logic               w_ovf;
    logic [6:0]         w_disp;
    logic [3:0]         w_tens;
    logic [3:0]         w_ones;
    logic [7:0]         w_ones_seg;
    logic [7:0]         w_pattern;

    function automatic logic [7:0] f_glyph(input logic [3:0] v);
        case (v)
            4'd0:    f_glyph = 8'hC0;
            4'd1:    f_glyph = 8'hF9;
            4'd2:    f_glyph = 8'hA4;
            4'd3:    f_glyph = 8'hB0;
            4'd4:    f_glyph = 8'h99;
            4'd5:    f_glyph = 8'h92;
            4'd6:    f_glyph = 8'h82;
            4'd7:    f_glyph = 8'hF8;
            4'd8:    f_glyph = 8'h80;
            4'd9:    f_glyph = 8'h90;
            default: f_glyph = c_SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        w_wrap        = (r_ref_cnt == c_REF_MAX);
        w_next_idx    = r_digit_idx + 2'd1;
        w_frame_start = w_wrap && (r_digit_idx == 2'd3);
        w_avail       = {1'b0, ~drop_tea} + {1'b0, ~drop_coke} + {1'b0, ~drop_sprite};

        w_nxt_money = w_frame_start ? money   : r_snap_money;
        w_nxt_state = w_frame_start ? state   : r_snap_state;
        w_nxt_avail = w_frame_start ? w_avail : r_snap_avail;

        // Blink only runs across consecutive change-return frames; the entry
        // frame and any idle frame force the counter and phase back to zero.
        w_nxt_frame = r_frame_cnt;
        w_nxt_blink = r_blink;
        if (w_frame_start) begin
            if (!(state && r_snap_state)) begin
                w_nxt_frame = '0;
                w_nxt_blink = 1'b0;
            end else if (r_frame_cnt == c_FRM_MAX) begin
                w_nxt_frame = '0;
                w_nxt_blink = ~r_blink;
            end else begin
                w_nxt_frame = r_frame_cnt + c_FRM_W'(1);
            end
        end

        // Pattern for the digit about to be lit, rendered from post-edge state.
        w_ovf      = (w_nxt_money > 8'd99);
        w_disp     = w_ovf ? 7'd99 : w_nxt_money[6:0];
        w_tens     = 4'(w_disp / 7'd10);
        w_ones     = 4'(w_disp % 7'd10);
        w_ones_seg = f_glyph(w_ones);

        case (w_next_idx)
            2'd0:    w_pattern = w_nxt_blink ? c_SEG_BLANK : {~w_ovf, w_ones_seg[6:0]};
            2'd1:    w_pattern = (w_nxt_blink || (w_tens == 4'd0)) ? c_SEG_BLANK : f_glyph(w_tens);
            2'd2:    w_pattern = f_glyph({2'b00, w_nxt_avail});
            default: w_pattern = w_nxt_state ? c_SEG_C : c_SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_ref_cnt    <= '0;
            r_digit_idx  <= 2'd0;
            r_snap_money <= 8'd0;
            r_snap_state <= 1'b0;
            r_snap_avail <= 2'd0;
            r_frame_cnt  <= '0;
            r_blink      <= 1'b0;
            DIGIT        <= 4'b1110;
            DISPLAY      <= 8'hC0;
        end else begin
            r_ref_cnt    <= w_wrap ? '0 : r_ref_cnt + c_REF_W'(1);
            r_snap_money <= w_nxt_money;
            r_snap_state <= w_nxt_state;
            r_snap_avail <= w_nxt_avail;
            r_frame_cnt  <= w_nxt_frame;
            r_blink      <= w_nxt_blink;
            if (w_wrap) begin
                r_digit_idx <= w_next_idx;
                DIGIT       <= ~(4'b0001 << w_next_idx);
                DISPLAY     <= w_pattern;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vend_display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vend_display_scan                                            |
// | Purpose  : frame-level scoreboard bench for vend_display_scan.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vend_display_scan;

    localparam int REFRESH_DIV = 4;
    localparam int BLINK_DIV   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] money = 8'd0;
    logic       state = 1'b0;
    logic       drop_tea = 1'b1;
    logic       drop_coke = 1'b1;
    logic       drop_sprite = 1'b1;
    logic [3:0] DIGIT;
    logic [7:0] DISPLAY;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];
    logic [7:0]  cap_disp[4];
    logic [3:0]  cap_dig[4];
    int          cap_dwell[4];

    always #5 clk = ~clk;

    vend_display_scan #(
        .REFRESH_DIV(REFRESH_DIV),
        .BLINK_DIV  (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .money      (money),
        .state      (state),
        .drop_tea   (drop_tea),
        .drop_coke  (drop_coke),
        .drop_sprite(drop_sprite),
        .DIGIT      (DIGIT),
        .DISPLAY    (DISPLAY)
    );

    function automatic logic [7:0] glyph(input int v);
        case (v)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // drops = {drop_sprite, drop_coke, drop_tea}; a 0 means purchasable
    function automatic logic [31:0] exp_pat(input logic [7:0] m, input logic s,
                                            input logic [2:0] drops, input logic ph);
        int v, t, o, av;
        logic [7:0] d0, d1, d2, d3;
        v  = (m > 8'd99) ? 99 : int'(m);
        t  = v / 10;
        o  = v % 10;
        av = 3 - $countones(drops);
        d0 = ph ? 8'hFF : ((m > 8'd99) ? (glyph(o) & 8'h7F) : glyph(o));
        d1 = (ph || t == 0) ? 8'hFF : glyph(t);
        d2 = glyph(av);
        d3 = s ? 8'hC6 : 8'hFF;
        return {d3, d2, d1, d0};
    endfunction

    // Applies inputs for the next frame and records what that frame must show.
    task automatic drive(input logic [7:0] m, input logic s, input logic [2:0] drops, input logic ph);
        money = m;
        state = s;
        {drop_sprite, drop_coke, drop_tea} = drops;
        sb_q.push_back(exp_pat(m, s, drops, ph));
    endtask

    // Called at the first negedge of a frame; returns at the first negedge of the next.
    task automatic capture_frame(input int chg_a, input logic [7:0] val_a,
                                 input int chg_b, input logic [7:0] val_b);
        int n;
        for (int d = 0; d < 4; d++) begin
            cap_dig[d]  = DIGIT;
            cap_disp[d] = DISPLAY;
            if (d == chg_a) money = val_a;
            if (d == chg_b) money = val_b;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (DIGIT === cap_dig[d] && n < 20);
            cap_dwell[d] = n;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        money = 8'd35;
        {drop_sprite, drop_coke, drop_tea} = 3'b000;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (DIGIT !== 4'b1110 || DISPLAY !== 8'hC0) begin
            n_err++;
            $display("FAIL reset_early got DIGIT=%b DISPLAY=%h want 1110/c0", DIGIT, DISPLAY);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (DIGIT !== 4'b1110 || DISPLAY !== 8'hC0) begin
            n_err++;
            $display("FAIL reset_held got DIGIT=%b DISPLAY=%h want 1110/c0", DIGIT, DISPLAY);
        end
        rst_n = 1'b0;
        sb_q.push_back(exp_pat(8'd0, 1'b0, 3'b111, 1'b0));
    endtask

    task automatic test_scan();
        logic [31:0] e;
        logic [3:0]  de;
        for (int i = 0; i < 2; i++) begin
            drive(8'd35, 1'b0, 3'b000, 1'b0);
            capture_frame(-1, 8'd0, -1, 8'd0);
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL scan f%0d scoreboard empty", i);
                continue;
            end
            e = sb_q.pop_front();
            for (int d = 0; d < 4; d++) begin
                de = ~(4'b0001 << d);
                if (cap_disp[d] !== e[8*d +: 8]) begin
                    n_err++;
                    $display("FAIL scan f%0d d%0d DISPLAY got %h want %h", i, d, cap_disp[d], e[8*d +: 8]);
                end
                n_cmp++;
                if (cap_dig[d] !== de || cap_dwell[d] != REFRESH_DIV) begin
                    n_err++;
                    $display("FAIL scan_dig f%0d d%0d got %b x%0d want %b x%0d", i, d, cap_dig[d], cap_dwell[d], de, REFRESH_DIV);
                end
                n_cmp++;
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0]  tm[3];
        logic [2:0]  td[3];
        logic [31:0] e;
        tm = '{8'd5, 8'd0, 8'd20};
        td = '{3'b110, 3'b110, 3'b111};
        for (int i = 0; i < 3; i++) begin
            drive(tm[i], 1'b0, td[i], 1'b0);
            capture_frame(-1, 8'd0, -1, 8'd0);
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL lead0 f%0d scoreboard empty", i);
                continue;
            end
            e = sb_q.pop_front();
            for (int d = 0; d < 4; d++) begin
                n_cmp++;
                if (cap_disp[d] !== e[8*d +: 8] || cap_dwell[d] != REFRESH_DIV) begin
                    n_err++;
                    $display("FAIL lead0 f%0d d%0d got %h x%0d want %h x%0d", i, d, cap_disp[d], cap_dwell[d], e[8*d +: 8], REFRESH_DIV);
                end
            end
        end
    endtask

    task automatic test_midframe();
        logic [31:0] e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                // money moves during digit0 (to 33) and digit2 (to 45) of a frame showing 20
                sb_q.push_back(exp_pat(8'd45, 1'b0, 3'b111, 1'b0));
                capture_frame(0, 8'd33, 2, 8'd45);
            end else begin
                drive(8'd45, 1'b0, 3'b111, 1'b0);
                capture_frame(-1, 8'd0, -1, 8'd0);
            end
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL midframe f%0d scoreboard empty", i);
                continue;
            end
            e = sb_q.pop_front();
            for (int d = 0; d < 4; d++) begin
                n_cmp++;
                if (cap_disp[d] !== e[8*d +: 8]) begin
                    n_err++;
                    $display("FAIL midframe f%0d d%0d got %h want %h", i, d, cap_disp[d], e[8*d +: 8]);
                end
            end
        end
    endtask

    task automatic test_blink();
        logic        ts[12];
        logic        tp[12];
        logic [31:0] e;
        ts = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            drive(8'd30, ts[i], 3'b001, tp[i]);
            capture_frame(-1, 8'd0, -1, 8'd0);
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL blink f%0d scoreboard empty", i);
                continue;
            end
            e = sb_q.pop_front();
            for (int d = 0; d < 4; d++) begin
                n_cmp++;
                if (cap_disp[d] !== e[8*d +: 8]) begin
                    n_err++;
                    $display("FAIL blink f%0d d%0d got %h want %h", i, d, cap_disp[d], e[8*d +: 8]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0]  tm[4];
        logic [31:0] e;
        tm = '{8'd120, 8'd99, 8'd100, 8'd255};
        for (int i = 0; i < 4; i++) begin
            drive(tm[i], 1'b0, 3'b111, 1'b0);
            capture_frame(-1, 8'd0, -1, 8'd0);
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL overflow f%0d scoreboard empty", i);
                continue;
            end
            e = sb_q.pop_front();
            for (int d = 0; d < 4; d++) begin
                n_cmp++;
                if (cap_disp[d] !== e[8*d +: 8]) begin
                    n_err++;
                    $display("FAIL overflow f%0d d%0d got %h want %h", i, d, cap_disp[d], e[8*d +: 8]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic        tp[5];
        logic [31:0] e;
        logic [3:0]  de;
        tp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                repeat (6) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                n_cmp++;
                if (DIGIT !== 4'b1110 || DISPLAY !== 8'hC0) begin
                    n_err++;
                    $display("FAIL reset_mid got DIGIT=%b DISPLAY=%h want 1110/c0", DIGIT, DISPLAY);
                end
                rst_n = 1'b0;
                sb_q.delete();
                sb_q.push_back(exp_pat(8'd0, 1'b0, 3'b111, 1'b0));
            end
            if (i < 4) drive(8'd30, 1'b1, 3'b000, tp[i]);
            capture_frame(-1, 8'd0, -1, 8'd0);
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL reset_mid f%0d scoreboard empty", i);
                continue;
            end
            e = sb_q.pop_front();
            for (int d = 0; d < 4; d++) begin
                de = ~(4'b0001 << d);
                n_cmp++;
                if (cap_disp[d] !== e[8*d +: 8] || cap_dig[d] !== de || cap_dwell[d] != REFRESH_DIV) begin
                    n_err++;
                    $display("FAIL reset_mid f%0d d%0d got %h/%b x%0d want %h/%b x%0d", i, d,
                             cap_disp[d], cap_dig[d], cap_dwell[d], e[8*d +: 8], de, REFRESH_DIV);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan();
        test_leading_zero();
        test_midframe();
        test_blink();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
